// File: rtl/instruction_memory_pipelined.sv
// Registered-output instruction memory: one-cycle fetch into a 2-entry response
// buffer, run-time loader port, and NOP+fault code for misaligned or out-of-range PCs.
module instruction_memory_pipelined #(
    parameter int              XLEN   = 32,
    parameter int              ADDR_W = 32,
    parameter int              DEPTH  = 32,
    parameter logic [XLEN-1:0] NOP    = 'h00000013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [XLEN-1:0]          resp_inst,
    output logic [ADDR_W-1:0]        resp_pc,
    output logic [1:0]               resp_fault,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [XLEN-1:0]          ld_data,
    output logic [7:0]               fault_cnt
);
    localparam int IW = $clog2(DEPTH);

    logic [XLEN-1:0]   mem [DEPTH];
    logic [XLEN-1:0]   buf_inst  [2];
    logic [ADDR_W-1:0] buf_pc    [2];
    logic [1:0]        buf_fault [2];
    logic              wptr, rptr;
    logic [1:0]        count;
    logic              push, pop;
    logic [ADDR_W-3:0] word_idx;
    logic              in_range;
    logic [XLEN-1:0]   rd_inst;
    logic [1:0]        rd_fault;

    assign resp_valid = (count != 2'd0);
    assign pop        = resp_valid & resp_ready;
    assign req_ready  = rst_n & ~ld_en & ~flush & ((count < 2'd2) | pop);
    assign push       = req_valid & req_ready;

    // Full-width compare so high address bits never alias into the array.
    assign word_idx = req_addr[ADDR_W-1:2];
    assign in_range = word_idx < (ADDR_W-2)'(DEPTH);

    always_comb begin
        rd_inst  = mem[word_idx[IW-1:0]];
        rd_fault = 2'b00;
        if (req_addr[1:0] != 2'b00) begin
            rd_inst  = NOP;
            rd_fault = 2'b01;
        end else if (!in_range) begin
            rd_inst  = NOP;
            rd_fault = 2'b10;
        end
    end

    // Array is deliberately not reset so loaded programs survive a core reset.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wptr]  <= rd_inst;
            buf_pc[wptr]    <= req_addr;
            buf_fault[wptr] <= rd_fault;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    count <= count + 2'd1;
                    wptr  <= ~wptr;
                end
                2'b01: begin
                    count <= count - 2'd1;
                    rptr  <= ~rptr;
                end
                2'b11: begin
                    wptr <= ~wptr;
                    rptr <= ~rptr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fault_cnt <= 8'd0;
        else if (push && rd_fault != 2'b00 && fault_cnt != 8'hFF)
            fault_cnt <= fault_cnt + 8'd1;
    end

    assign resp_inst  = resp_valid ? buf_inst[rptr]  : '0;
    assign resp_pc    = resp_valid ? buf_pc[rptr]    : '0;
    assign resp_fault = resp_valid ? buf_fault[rptr] : '0;
endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// Bench for instruction_memory_pipelined: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_instruction_memory_pipelined;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, req_valid, req_ready, resp_valid, resp_ready, ld_en;
    logic [31:0] req_addr, resp_inst, resp_pc, ld_data;
    logic [1:0]  resp_fault;
    logic [4:0]  ld_addr;
    logic [7:0]  fault_cnt;

    always #5 clk = ~clk;

    instruction_memory_pipelined dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst),
        .resp_pc(resp_pc), .resp_fault(resp_fault),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .fault_cnt(fault_cnt)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  fault;
    } resp_t;

    typedef struct {
        logic        rv;
        logic [31:0] addr;
        logic        rr, fl, le;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_ready, e_valid;
        logic [31:0] e_inst;
        logic [1:0]  e_fault;
    } vec_t;

    // Reference model: a plain FIFO of expected responses and a word array.
    resp_t       q[$];
    logic [31:0] mmem [32];
    int          mfcnt;
    int          n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] a, input logic rr,
                         input logic fl, input logic le, input logic [4:0] la,
                         input logic [31:0] ld);
        req_valid = rv; req_addr = a; resp_ready = rr; flush = fl;
        ld_en = le; ld_addr = la; ld_data = ld;
        #1;
    endtask

    function automatic logic model_ready();
        return !ld_en && !flush && (q.size() < 2 || resp_ready);
    endfunction

    task automatic check_model();
        chk("req_ready", req_ready, model_ready());
        chk("resp_valid", resp_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("resp_inst", resp_inst, q[0].inst);
            chk("resp_pc", resp_pc, q[0].pc);
            chk("resp_fault", resp_fault, q[0].fault);
        end else begin
            chk("idle_outputs", {resp_inst, resp_pc, resp_fault}, 66'd0);
        end
        chk("fault_cnt", fault_cnt, mfcnt);
    endtask

    task automatic advance();
        resp_t r;
        logic  acc;
        acc = req_valid && model_ready();
        if (flush) q.delete();
        else if (resp_ready && q.size() > 0) void'(q.pop_front());
        if (acc) begin
            r.pc = req_addr;
            if (req_addr % 4 != 0) begin r.fault = 2'b01; r.inst = 32'h13; end
            else if (req_addr / 4 >= 32) begin r.fault = 2'b10; r.inst = 32'h13; end
            else begin r.fault = 2'b00; r.inst = mmem[req_addr / 4]; end
            q.push_back(r);
            if (r.fault != 0 && mfcnt < 255) mfcnt++;
        end
        if (ld_en) mmem[ld_addr] = ld_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic rv, input logic [31:0] a, input logic rr,
                        input logic fl, input logic le, input logic [4:0] la,
                        input logic [31:0] ld);
        drive(rv, a, rr, fl, le, la, ld);
        check_model();
        advance();
    endtask

    function automatic vec_t mk(input logic rv, input logic [31:0] a, input logic rr,
                                input logic le, input logic [4:0] la, input logic [31:0] ld,
                                input logic er, input logic ev, input logic [31:0] ei,
                                input logic [1:0] ef);
        vec_t v;
        v.rv = rv; v.addr = a; v.rr = rr; v.fl = 1'b0; v.le = le; v.la = la; v.ld = ld;
        v.e_ready = er; v.e_valid = ev; v.e_inst = ei; v.e_fault = ef;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        for (int i = 0; i < 32; i++) mmem[i] = 32'h0;
        mfcnt = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_fault_cnt", fault_cnt, 8'd0);
        chk("rst_req_ready", req_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Loader, in-order fetch, backpressure and fault vectors.
        tbl.push_back(mk(0, 0, 1, 1, 0, 32'h00500093, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 32'h00A08113, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 2, 32'h002081B3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 3, 32'h00208263, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h0, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 32'h4, 1, 0, 0, 0, 1, 1, 32'h00500093, 0));
        tbl.push_back(mk(1, 32'h8, 1, 0, 0, 0, 1, 1, 32'h00A08113, 0));
        tbl.push_back(mk(1, 32'hC, 1, 0, 0, 0, 1, 1, 32'h002081B3, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 32'h00208263, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 32'h4, 0, 0, 0, 0, 1, 1, 32'h00500093, 0));
        tbl.push_back(mk(1, 32'h8, 0, 0, 0, 0, 0, 1, 32'h00500093, 0));
        tbl.push_back(mk(1, 32'h8, 1, 0, 0, 0, 1, 1, 32'h00500093, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 32'h00A08113, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 32'h002081B3, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 32'h6, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 32'h80, 1, 0, 0, 0, 1, 1, 32'h13, 2'b01));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 32'h13, 2'b10));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i].rv, tbl[i].addr, tbl[i].rr, tbl[i].fl, tbl[i].le, tbl[i].la, tbl[i].ld);
            check_model();
            chk($sformatf("vec%0d_ready", i), req_ready, tbl[i].e_ready);
            chk($sformatf("vec%0d_valid", i), resp_valid, tbl[i].e_valid);
            chk($sformatf("vec%0d_inst", i), resp_inst, tbl[i].e_inst);
            chk($sformatf("vec%0d_fault", i), resp_fault, tbl[i].e_fault);
            advance();
        end
        chk("fault_cnt_two", fault_cnt, 8'd2);

        // Saturation: 300 misaligned fetches.
        for (int i = 0; i < 300; i++) step(1, 32'h2, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("fault_cnt_sat", fault_cnt, 8'd255);

        // Flush with two buffered entries.
        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(1, 32'h4, 0, 0, 0, 0, 0);
        drive(1, 32'h8, 1, 1, 0, 0, 0);
        chk("flush_req_ready", req_ready, 1'b0);
        check_model();
        advance();
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("flush_resp_valid", resp_valid, 1'b0);
        advance();
        step(1, 32'h0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("post_flush_inst", resp_inst, 32'h00500093);
        advance();

        // Loader blocks fetch while buffered entries drain.
        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(1, 32'h4, 0, 0, 0, 0, 0);
        drive(1, 32'h14, 1, 0, 1, 5, 32'hDEADBEEF);
        chk("ld_req_ready", req_ready, 1'b0);
        check_model();
        advance();
        step(1, 32'h14, 1, 0, 1, 6, 32'hCAFEF00D);
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 32'h14, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("ld_new_inst", resp_inst, 32'hDEADBEEF);
        advance();

        // Asynchronous reset with two entries buffered.
        step(1, 32'h3, 0, 0, 0, 0, 0);
        step(1, 32'h4, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_resp_valid", resp_valid, 1'b0);
        chk("arst_fault_cnt", fault_cnt, 8'd0);
        chk("arst_resp_inst", resp_inst, 32'd0);
        q.delete();
        mfcnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'h14, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("arst_keep_mem", resp_inst, 32'hDEADBEEF);
        advance();

        // Fill the whole array, then random traffic.
        for (int i = 0; i < 32; i++) step(0, 0, 1, 0, 1, 5'(i), $urandom);
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] a;
            int          sel;
            sel = $urandom_range(0, 99);
            if (sel < 70)      a = 32'($urandom_range(0, 31)) << 2;
            else if (sel < 85) a = $urandom | 32'h1;
            else               a = $urandom & 32'hFFFF_FFFC;
            step($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                 5'($urandom_range(0, 31)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
